// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
// Shared types and constants for the SRAM arbiter slice: the sequencer
// state encoding, port identifiers and the idle level of the active-low
// SRAM strobes.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

    localparam logic PORT_IF    = 1'b0;
    localparam logic PORT_MEM   = 1'b1;

    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-input round-robin arbiter. A masked requester is not eligible. When
// both are eligible, the one not granted last wins. The last-grant flag
// updates only when en_i is high and a grant is produced.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_i[1:0]     requests, bit index = port ID
//   mask_i[1:0]    per-port mask (1 = not eligible this cycle)
//   en_i           grant is being taken this cycle
//   gnt_valid_o    some port is eligible
//   gnt_id_o       winning port ID
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       en_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic       last_q, last_d;
    logic [1:0] elig;

    assign elig = req_i & ~mask_i;

    always_comb begin
        gnt_valid_o = |elig;
        gnt_id_o    = PORT_IF;
        if (elig == 2'b11) begin
            gnt_id_o = ~last_q;
        end else if (elig[PORT_MEM]) begin
            gnt_id_o = PORT_MEM;
        end
        last_d = last_q;
        if (en_i && gnt_valid_o) begin
            last_d = gnt_id_o;
        end
    end

    // Reset to IF so the first contended grant goes to MEM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one asynchronous SRAM between the instruction-fetch port and the
// MEM-stage load/store port. Grants one access at a time, sequences the
// SRAM strobes, drives the tristate bus during writes and raises per-port
// stalls while a request is outstanding.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   if_req_i, if_addr_i              fetch request and word address
//   if_rdata_o, if_ready_o           fetched word, one-cycle completion
//   mem_rd_i, mem_wr_i               load / store request (both = store)
//   mem_addr_i, mem_wdata_i          load/store address and store data
//   mem_rdata_o, mem_ready_o         load data, one-cycle completion
//   stall_if_o, stall_mem_o          request pending and not ready
//   sram_addr_o, sram_data_io        SRAM address and bidirectional data
//   sram_en_n_o, sram_oe_n_o, sram_we_n_o  active-low SRAM strobes
//
// state       | meaning
// ST_IDLE     | no access; arbitrate eligible requests
// ST_READ     | en/oe low, bus released; data captured at end of cycle
// ST_WR_SETUP | en low, bus driven, address/data settle
// ST_WR_PULSE | en and we low, bus driven
// ST_WR_HOLD  | en low, bus driven, data held past we rising edge
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int SRAM_AW = 18,
    parameter logic [SRAM_AW-ADDR_W-1:0] SRAM_BANK = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    output logic [DATA_W-1:0]  if_rdata_o,
    output logic               if_ready_o,
    input  logic               mem_rd_i,
    input  logic               mem_wr_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    output logic [DATA_W-1:0]  mem_rdata_o,
    output logic               mem_ready_o,
    output logic               stall_if_o,
    output logic               stall_mem_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0]  sram_data_io,
    output logic               sram_en_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o
);

    state_e              state_q, state_d;
    logic                port_q, port_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;
    logic                bus_drive;
    logic                mem_req;
    logic                gnt_valid;
    logic                gnt_id;

    assign mem_req = mem_rd_i | mem_wr_i;

    // A port whose ready is up this cycle has just completed; masking it
    // keeps the same port from being re-granted on its own ready cycle.
    rr_arb2 u_rr_arb2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       ({mem_req, if_req_i}),
        .mask_i      ({mem_ready_q, if_ready_q}),
        .en_i        (state_q == ST_IDLE),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        sram_en_n_o = STROBE_OFF;
        sram_oe_n_o = STROBE_OFF;
        sram_we_n_o = STROBE_OFF;
        bus_drive   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    port_d = gnt_id;
                    if (gnt_id == PORT_MEM) begin
                        addr_d  = mem_addr_i;
                        wdata_d = mem_wdata_i;
                        state_d = mem_wr_i ? ST_WR_SETUP : ST_READ;
                    end else begin
                        addr_d  = if_addr_i;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                sram_en_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
                state_d     = ST_IDLE;
                if (port_q == PORT_MEM) begin
                    mem_rdata_d = sram_data_io;
                    mem_ready_d = 1'b1;
                end else begin
                    if_rdata_d  = sram_data_io;
                    if_ready_d  = 1'b1;
                end
            end
            ST_WR_SETUP: begin
                sram_en_n_o = 1'b0;
                bus_drive   = 1'b1;
                state_d     = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                sram_en_n_o = 1'b0;
                sram_we_n_o = 1'b0;
                bus_drive   = 1'b1;
                state_d     = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                sram_en_n_o = 1'b0;
                bus_drive   = 1'b1;
                state_d     = ST_IDLE;
                mem_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            port_q      <= PORT_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign sram_data_io = bus_drive ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr_o  = {SRAM_BANK, addr_q};

    assign if_rdata_o   = if_rdata_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign if_ready_o   = if_ready_q;
    assign mem_ready_o  = mem_ready_q;

    assign stall_if_o   = if_req_i & ~if_ready_q;
    assign stall_mem_o  = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// two-port run checked against a transaction-level timing/memory model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if, stall_mem;
    logic [17:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_en_n, sram_oe_n, sram_we_n;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_rdata_o   (if_rdata),
        .if_ready_o   (if_ready),
        .mem_rd_i     (mem_rd),
        .mem_wr_i     (mem_wr),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_rdata_o  (mem_rdata),
        .mem_ready_o  (mem_ready),
        .stall_if_o   (stall_if),
        .stall_mem_o  (stall_mem),
        .sram_addr_o  (sram_addr),
        .sram_data_io (sram_data),
        .sram_en_n_o  (sram_en_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n)
    );

    // Asynchronous SRAM model. The probe value is put on the bus by the
    // bench when the arbiter should have released it; any arbiter drive
    // corrupts the probe.
    localparam logic [15:0] PROBE = 16'hA5C3;
    logic [15:0] sram_mem [0:65535];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0, bd_data = '0;
    logic        probe_en = 1'b0;
    wire         model_rd = !sram_en_n && !sram_oe_n && sram_we_n;

    assign sram_data = model_rd ? sram_mem[sram_addr[15:0]] :
                       (probe_en ? PROBE : 16'hzzzz);

    always @(posedge clk) begin
        if (bd_we)
            sram_mem[bd_addr] <= bd_data;
        else if (!sram_en_n && !sram_we_n)
            sram_mem[sram_addr[15:0]] <= sram_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_load(input logic [15:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        probe_en = 1'b1;
        tick();
        vectors++;
        if ({sram_en_n, sram_oe_n, sram_we_n} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 111", {sram_en_n, sram_oe_n, sram_we_n});
        end
        vectors++;
        if (sram_data !== PROBE) begin
            miscompares++;
            $display("FAIL reset_bus: got %h want %h (released)", sram_data, PROBE);
        end
        vectors++;
        if ({sram_addr, if_rdata, mem_rdata} !== 50'd0) begin
            miscompares++;
            $display("FAIL reset_regs: addr %h if_rdata %h mem_rdata %h want 0", sram_addr, if_rdata, mem_rdata);
        end
        vectors++;
        if ({if_ready, mem_ready, stall_if, stall_mem} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {if_ready, mem_ready, stall_if, stall_mem});
        end
        probe_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_if_read();
        apply_reset();
        bd_load(16'h0004, 16'h4C01);
        if_req = 1'b1; if_addr = 16'h0004;
        #1;
        vectors++;
        if (stall_if !== 1'b1) begin
            miscompares++;
            $display("FAIL ifrd_stall_c0: got %b want 1", stall_if);
        end
        tick();
        vectors++;
        if ({sram_en_n, sram_oe_n, sram_we_n, stall_if, if_ready} !== 5'b00110) begin
            miscompares++;
            $display("FAIL ifrd_c1: got en/oe/we/stall/rdy %b want 00110", {sram_en_n, sram_oe_n, sram_we_n, stall_if, if_ready});
        end
        vectors++;
        if (sram_addr !== 18'h00004) begin
            miscompares++;
            $display("FAIL ifrd_addr: got %h want 00004", sram_addr);
        end
        tick();
        vectors++;
        if ({if_ready, stall_if, if_rdata} !== {2'b10, 16'h4C01}) begin
            miscompares++;
            $display("FAIL ifrd_c2: got rdy %b stall %b data %h want 1 0 4c01", if_ready, stall_if, if_rdata);
        end
        if_req = 1'b0;
        tick();
        vectors++;
        if ({if_ready, sram_en_n, sram_oe_n} !== 3'b011) begin
            miscompares++;
            $display("FAIL ifrd_c3: got rdy/en/oe %b want 011", {if_ready, sram_en_n, sram_oe_n});
        end
    endtask

    task automatic test_mem_write();
        logic exp_we;
        apply_reset();
        mem_wr = 1'b1; mem_addr = 16'h8010; mem_wdata = 16'h1234;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c <= 3) begin
                exp_we = (c == 2) ? 1'b0 : 1'b1;
                vectors++;
                if ({sram_en_n, sram_oe_n, sram_we_n, mem_ready} !== {2'b01, exp_we, 1'b0}) begin
                    miscompares++;
                    $display("FAIL wr_strobes_c%0d: got en/oe/we/rdy %b want 01%b0", c, {sram_en_n, sram_oe_n, sram_we_n, mem_ready}, exp_we);
                end
                vectors++;
                if (sram_data !== 16'h1234 || sram_addr !== 18'h08010) begin
                    miscompares++;
                    $display("FAIL wr_bus_c%0d: got data %h addr %h want 1234 08010", c, sram_data, sram_addr);
                end
            end else begin
                vectors++;
                if ({mem_ready, stall_mem, sram_en_n, sram_oe_n, sram_we_n} !== 5'b10111) begin
                    miscompares++;
                    $display("FAIL wr_done_c4: got rdy/stall/en/oe/we %b want 10111", {mem_ready, stall_mem, sram_en_n, sram_oe_n, sram_we_n});
                end
            end
        end
        mem_wr = 1'b0;
        tick();
        mem_rd = 1'b1;
        tick();
        tick();
        vectors++;
        if ({mem_ready, mem_rdata} !== {1'b1, 16'h1234}) begin
            miscompares++;
            $display("FAIL wr_readback: got rdy %b data %h want 1 1234", mem_ready, mem_rdata);
        end
        mem_rd = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic        exp_ifr, exp_memr;
        logic [17:0] exp_addr;
        apply_reset();
        bd_load(16'h0003, 16'h3333);
        bd_load(16'h0007, 16'h7777);
        if_req = 1'b1; if_addr = 16'h0003;
        mem_rd = 1'b1; mem_addr = 16'h0007;
        // MEM wins first; afterwards each port is granted on the other's
        // ready cycle, so completions alternate every two cycles.
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_memr = (c % 4 == 2);
            exp_ifr  = (c % 4 == 0);
            vectors++;
            if ({if_ready, mem_ready} !== {exp_ifr, exp_memr}) begin
                miscompares++;
                $display("FAIL cont_ready_c%0d: got if/mem %b want %b", c, {if_ready, mem_ready}, {exp_ifr, exp_memr});
            end
            if (c % 2 == 1) begin
                exp_addr = (c % 4 == 1) ? 18'h00007 : 18'h00003;
                vectors++;
                if (sram_addr !== exp_addr || sram_oe_n !== 1'b0) begin
                    miscompares++;
                    $display("FAIL cont_grant_c%0d: got addr %h oe %b want %h 0", c, sram_addr, sram_oe_n, exp_addr);
                end
            end
        end
        vectors++;
        if ({if_rdata, mem_rdata} !== {16'h3333, 16'h7777}) begin
            miscompares++;
            $display("FAIL cont_data: got if %h mem %h want 3333 7777", if_rdata, mem_rdata);
        end
        if_req = 1'b0; mem_rd = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic        exp_rdy, exp_read;
        logic [15:0] exp_data;
        apply_reset();
        bd_load(16'h0000, 16'h1000);
        bd_load(16'h0001, 16'h2001);
        if_req = 1'b1; if_addr = 16'h0000;
        // Read 0 granted at edge 0, READ c1, ready c2 (masked, no grant);
        // read 1 granted at edge 3, READ c4, ready c5.
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp_rdy  = (c == 2) || (c == 5);
            exp_read = (c == 1) || (c == 4);
            exp_data = (c >= 5) ? 16'h2001 : ((c >= 2) ? 16'h1000 : 16'h0000);
            vectors++;
            if ({if_ready, ~sram_oe_n, if_rdata} !== {exp_rdy, exp_read, exp_data}) begin
                miscompares++;
                $display("FAIL b2b_c%0d: got rdy %b read %b data %h want %b %b %h", c, if_ready, ~sram_oe_n, if_rdata, exp_rdy, exp_read, exp_data);
            end
            if (c == 2) if_addr = 16'h0001;
            if (c == 5) if_req = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        int strobe_hits;
        int ready_hits;
        apply_reset();
        mem_wr = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h5555;
        tick();
        tick();
        vectors++;
        if (sram_we_n !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pulse: got we_n %b want 0", sram_we_n);
        end
        rst = 1'b1;
        tick();
        probe_en = 1'b1;
        #1;
        vectors++;
        if ({sram_en_n, sram_oe_n, sram_we_n, mem_ready} !== 4'b1110 || sram_data !== PROBE) begin
            miscompares++;
            $display("FAIL abort_release: got en/oe/we/rdy %b bus %h want 1110 %h", {sram_en_n, sram_oe_n, sram_we_n, mem_ready}, sram_data, PROBE);
        end
        rst = 1'b0;
        mem_wr = 1'b0;
        strobe_hits = 0;
        ready_hits = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (!sram_en_n || !sram_oe_n || !sram_we_n) strobe_hits++;
            if (mem_ready) ready_hits++;
        end
        vectors++;
        if (strobe_hits != 0 || ready_hits != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got strobe cycles %0d ready cycles %0d want 0 0", strobe_hits, ready_hits);
        end
        probe_en = 1'b0;
    endtask

    task automatic test_rd_wr_both();
        apply_reset();
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0100; mem_wdata = 16'hBEEF;
        tick();
        tick();
        vectors++;
        if ({sram_en_n, sram_oe_n, sram_we_n} !== 3'b010) begin
            miscompares++;
            $display("FAIL both_pulse: got en/oe/we %b want 010", {sram_en_n, sram_oe_n, sram_we_n});
        end
        tick();
        tick();
        vectors++;
        if (mem_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL both_ready: got %b want 1", mem_ready);
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        tick();
        vectors++;
        if (sram_mem[16'h0100] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL both_mem: got %h want beef", sram_mem[16'h0100]);
        end
    endtask

    // Randomized run. The reference model works per transaction: a grant
    // taken at the end of cycle k completes k+2 (read) or k+4 (write)
    // cycles later, and the arbiter is free again on that completion cycle.
    task automatic test_random();
        logic [15:0] ref_mem [0:15];
        int          free_at, if_done_at, mem_done_at;
        logic        last_mem, pick_mem, el_if, el_mem, exp_ifr, exp_memr;
        logic        mem_pend_rd;
        logic [15:0] if_pend, mem_pend, exp_if_rdata, exp_mem_rdata, d;
        int          op;
        apply_reset();
        for (int a = 0; a < 16; a++) begin
            d = 16'($urandom);
            ref_mem[a] = d;
            bd_load(16'(a), d);
        end
        free_at = 0; if_done_at = -1; mem_done_at = -1;
        last_mem = 1'b0; mem_pend_rd = 1'b0;
        if_pend = '0; mem_pend = '0; exp_if_rdata = '0; exp_mem_rdata = '0;
        for (int k = 0; k < 500; k++) begin
            exp_ifr  = (k == if_done_at);
            exp_memr = (k == mem_done_at);
            if (exp_ifr) exp_if_rdata = if_pend;
            if (exp_memr && mem_pend_rd) exp_mem_rdata = mem_pend;
            vectors++;
            if ({if_ready, mem_ready} !== {exp_ifr, exp_memr}) begin
                miscompares++;
                $display("FAIL rnd_ready k=%0d: got if/mem %b want %b", k, {if_ready, mem_ready}, {exp_ifr, exp_memr});
            end
            vectors++;
            if (if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
                miscompares++;
                $display("FAIL rnd_data k=%0d: got if %h mem %h want %h %h", k, if_rdata, mem_rdata, exp_if_rdata, exp_mem_rdata);
            end
            if (!if_req || exp_ifr) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = 16'($urandom_range(0, 15));
            end
            if (!(mem_rd || mem_wr) || exp_memr) begin
                op        = int'($urandom_range(0, 3));
                mem_rd    = (op == 1) || (op == 3);
                mem_wr    = (op == 2) || (op == 3);
                mem_addr  = 16'($urandom_range(0, 15));
                mem_wdata = 16'($urandom);
            end
            #1;
            vectors++;
            if ({stall_if, stall_mem} !== {if_req && !exp_ifr, (mem_rd || mem_wr) && !exp_memr}) begin
                miscompares++;
                $display("FAIL rnd_stall k=%0d: got %b want %b", k, {stall_if, stall_mem}, {if_req && !exp_ifr, (mem_rd || mem_wr) && !exp_memr});
            end
            if (k >= free_at) begin
                el_if  = if_req && !exp_ifr;
                el_mem = (mem_rd || mem_wr) && !exp_memr;
                pick_mem = (el_if && el_mem) ? !last_mem : el_mem;
                if (el_if || el_mem) begin
                    last_mem = pick_mem;
                    if (pick_mem && mem_wr) begin
                        ref_mem[mem_addr[3:0]] = mem_wdata;
                        mem_pend_rd = 1'b0;
                        mem_done_at = k + 4;
                        free_at     = k + 4;
                    end else if (pick_mem) begin
                        mem_pend    = ref_mem[mem_addr[3:0]];
                        mem_pend_rd = 1'b1;
                        mem_done_at = k + 2;
                        free_at     = k + 2;
                    end else begin
                        if_pend    = ref_mem[if_addr[3:0]];
                        if_done_at = k + 2;
                        free_at    = k + 2;
                    end
                end
            end
            tick();
        end
        if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
        test_reset();
        test_if_read();
        test_mem_write();
        test_contention();
        test_back_to_back();
        test_reset_abort();
        test_rd_wr_both();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
